status_reg_unit: RTL and testbench

STATUS_REG_UNIT -- requirements
Module: status_reg_unit

---
 rtl/status_reg_unit_pkg.sv | 25 ++
 rtl/status_reg_unit_if.sv | 34 +++
 rtl/status_reg_unit_flag_calc.sv | 32 +++
 rtl/status_reg_unit.sv | 90 +++++++++
 tb/tb_status_reg_unit.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/status_reg_unit_pkg.sv
// Shared definitions for the status register unit: ALU command encodings,
// NZCV bit positions and the shadow-register state enumeration.
package status_reg_unit_pkg;

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic {
    SH_IDLE  = 1'b0,
    SH_SAVED = 1'b1
  } shadow_state_e;

endpackage

// File: rtl/status_reg_unit_if.sv
// Execute-stage flag bus: ALU results and control into the unit, NZCV and
// shadow status out. master drives the stage side, slave is the flag unit.
interface status_reg_unit_if;
  logic [31:0] alu_res;
  logic        alu_cout;
  logic        op_a_msb;
  logic        op_b_msb;
  logic [3:0]  exe_cmd;
  logic        s_bit;
  logic        exe_valid;
  logic        stall;
  logic        flush;
  logic        wr_en;
  logic [3:0]  wr_data;
  logic        save_req;
  logic        restore_req;
  logic        n;
  logic        z;
  logic        c;
  logic        v;
  logic        shadow_valid;

  modport master (
    output alu_res, alu_cout, op_a_msb, op_b_msb, exe_cmd, s_bit, exe_valid,
           stall, flush, wr_en, wr_data, save_req, restore_req,
    input  n, z, c, v, shadow_valid
  );

  modport slave (
    input  alu_res, alu_cout, op_a_msb, op_b_msb, exe_cmd, s_bit, exe_valid,
           stall, flush, wr_en, wr_data, save_req, restore_req,
    output n, z, c, v, shadow_valid
  );
endinterface

// File: rtl/status_reg_unit_flag_calc.sv
// Combinational NZCV computation from the ALU result; C and V hold their
// current value for logical, move and unknown commands.
module flag_calc
  import status_reg_unit_pkg::*;
(
  input  logic [31:0] i_alu_res,
  input  logic        i_alu_cout,
  input  logic        i_op_a_msb,
  input  logic        i_op_b_msb,
  input  logic [3:0]  i_exe_cmd,
  input  logic [3:0]  i_flags,
  output logic [3:0]  o_flags
);

  always_comb begin
    o_flags         = i_flags;
    o_flags[FLAG_N] = i_alu_res[31];
    o_flags[FLAG_Z] = (i_alu_res == '0);
    case (i_exe_cmd)
      CMD_ADD, CMD_ADC: begin
        o_flags[FLAG_C] = i_alu_cout;
        o_flags[FLAG_V] = (i_op_a_msb == i_op_b_msb) && (i_alu_res[31] != i_op_a_msb);
      end
      CMD_SUB, CMD_SBC: begin
        o_flags[FLAG_C] = i_alu_cout;
        o_flags[FLAG_V] = (i_op_a_msb != i_op_b_msb) && (i_alu_res[31] != i_op_a_msb);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/status_reg_unit.sv
// Architectural NZCV register with a one-entry shadow (save/restore).
// Define FLAG_BYPASS_EN to expose next-edge flag values combinationally.
module status_reg_unit
  import status_reg_unit_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  status_reg_unit_if.slave bus
);

  logic [3:0]    r_flags;
  logic [3:0]    r_shadow;
  shadow_state_e r_state;

  logic [3:0]    w_calc;
  logic [3:0]    w_flags_nxt;
  logic [3:0]    w_shadow_nxt;
  logic [3:0]    w_flags_out;
  shadow_state_e w_state_nxt;
  logic          w_alu_upd;
  logic          w_restore;

  flag_calc u_flag_calc (
    .i_alu_res  (bus.alu_res),
    .i_alu_cout (bus.alu_cout),
    .i_op_a_msb (bus.op_a_msb),
    .i_op_b_msb (bus.op_b_msb),
    .i_exe_cmd  (bus.exe_cmd),
    .i_flags    (r_flags),
    .o_flags    (w_calc)
  );

  assign w_alu_upd = bus.exe_valid && bus.s_bit && !bus.stall && !bus.flush;
  assign w_restore = bus.restore_req && (r_state == SH_SAVED) && !bus.stall;

  // Shadow always captures the pre-update flags, so a save+restore pair swaps.
  always_comb begin
    w_flags_nxt  = r_flags;
    w_shadow_nxt = r_shadow;
    if (!bus.stall) begin
      if (w_restore)       w_flags_nxt = r_shadow;
      else if (bus.wr_en)  w_flags_nxt = bus.wr_data;
      else if (w_alu_upd)  w_flags_nxt = w_calc;
      if (bus.save_req)    w_shadow_nxt = r_flags;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags  <= '0;
      r_shadow <= '0;
    end else begin
      r_flags  <= w_flags_nxt;
      r_shadow <= w_shadow_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SH_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.stall) begin
      case (r_state)
        SH_IDLE:  if (bus.save_req) w_state_nxt = SH_SAVED;
        SH_SAVED: if (bus.restore_req && !bus.save_req) w_state_nxt = SH_IDLE;
        default:  w_state_nxt = SH_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.shadow_valid = (r_state == SH_SAVED);
  end

`ifdef FLAG_BYPASS_EN
  // w_flags_nxt already equals r_flags under stall, which suppresses bypass.
  assign w_flags_out = w_flags_nxt;
`else
  assign w_flags_out = r_flags;
`endif

  assign bus.n = w_flags_out[FLAG_N];
  assign bus.z = w_flags_out[FLAG_Z];
  assign bus.c = w_flags_out[FLAG_C];
  assign bus.v = w_flags_out[FLAG_V];

endmodule

// File: tb/tb_status_reg_unit.sv
// Scoreboard bench for status_reg_unit (registered-output build): a reference
// model predicts {NZCV, shadow_valid} per cycle, plus directed vector checks.
module tb_status_reg_unit;
  import status_reg_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  status_reg_unit_if bus_if ();

  status_reg_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [4:0]  sb_q[$];
  logic [3:0]  m_flags;
  logic [3:0]  m_shadow;
  logic        m_saved;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] dut_flags();
    return {bus_if.n, bus_if.z, bus_if.c, bus_if.v};
  endfunction

  task automatic idle_inputs();
    bus_if.alu_res     = '0;
    bus_if.alu_cout    = 1'b0;
    bus_if.op_a_msb    = 1'b0;
    bus_if.op_b_msb    = 1'b0;
    bus_if.exe_cmd     = '0;
    bus_if.s_bit       = 1'b0;
    bus_if.exe_valid   = 1'b0;
    bus_if.stall       = 1'b0;
    bus_if.flush       = 1'b0;
    bus_if.wr_en       = 1'b0;
    bus_if.wr_data     = '0;
    bus_if.save_req    = 1'b0;
    bus_if.restore_req = 1'b0;
  endtask

  task automatic model_push();
    logic [3:0] calc, nf, ns;
    logic       nsv;
    logic       r31;
    r31  = bus_if.alu_res[31];
    calc = m_flags;
    calc[3] = r31;
    calc[2] = (bus_if.alu_res == 32'd0);
    if (bus_if.exe_cmd == 4'b0010 || bus_if.exe_cmd == 4'b0011) begin
      calc[1] = bus_if.alu_cout;
      calc[0] = (bus_if.op_a_msb == bus_if.op_b_msb) && (r31 != bus_if.op_a_msb);
    end else if (bus_if.exe_cmd == 4'b0100 || bus_if.exe_cmd == 4'b0101) begin
      calc[1] = bus_if.alu_cout;
      calc[0] = (bus_if.op_a_msb != bus_if.op_b_msb) && (r31 != bus_if.op_a_msb);
    end
    nf = m_flags; ns = m_shadow; nsv = m_saved;
    if (!bus_if.stall) begin
      if (bus_if.restore_req && m_saved) nf = m_shadow;
      else if (bus_if.wr_en) nf = bus_if.wr_data;
      else if (bus_if.exe_valid && bus_if.s_bit && !bus_if.flush) nf = calc;
      if (bus_if.save_req) begin
        ns = m_flags; nsv = 1'b1;
      end else if (bus_if.restore_req) begin
        nsv = 1'b0;
      end
    end
    m_flags = nf; m_shadow = ns; m_saved = nsv;
    sb_q.push_back({nf, nsv});
  endtask

  task automatic step();
    logic [4:0] exp;
    model_push();
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    chk("sb", {dut_flags(), bus_if.shadow_valid}, exp);
    idle_inputs();
  endtask

  task automatic alu(input logic [3:0] cmd, input logic [31:0] res, input logic cout,
                     input logic a, input logic b, input logic s);
    bus_if.exe_cmd   = cmd;
    bus_if.alu_res   = res;
    bus_if.alu_cout  = cout;
    bus_if.op_a_msb  = a;
    bus_if.op_b_msb  = b;
    bus_if.s_bit     = s;
    bus_if.exe_valid = 1'b1;
    step();
  endtask

  task automatic wr(input logic [3:0] d);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_data = d;
    step();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    m_flags = '0; m_shadow = '0; m_saved = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", dut_flags(), 4'b0000);
    chk("rst_sv", bus_if.shadow_valid, 1'b0);
    rst_n = 1'b1;

    alu(CMD_ADD, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("add_ovf", dut_flags(), 4'b1001);
    alu(CMD_SUB, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("sub_zero", dut_flags(), 4'b0110);
    wr(4'b0011);
    chk("wr", dut_flags(), 4'b0011);
    alu(CMD_AND, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("and_s", dut_flags(), 4'b0111);
    alu(CMD_AND, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("and_nos", dut_flags(), 4'b0111);
    alu(CMD_MOV, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mov", dut_flags(), 4'b1011);
    alu(4'b1111, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("unk_cmd", dut_flags(), 4'b0111);
    alu(CMD_ADC, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("adc_ovf", dut_flags(), 4'b1011);
    alu(CMD_SBC, 32'h1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("sbc_ovf", dut_flags(), 4'b0001);

    wr(4'b1010);
    bus_if.save_req = 1'b1; step();
    chk("save_sv", bus_if.shadow_valid, 1'b1);
    wr(4'b0101);
    chk("wr_saved", dut_flags(), 4'b0101);
    bus_if.restore_req = 1'b1; step();
    chk("restore_flags", dut_flags(), 4'b1010);
    chk("restore_sv", bus_if.shadow_valid, 1'b0);

    bus_if.stall = 1'b1; alu(CMD_ADD, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("stall_hold", dut_flags(), 4'b1010);
    bus_if.flush = 1'b1; alu(CMD_ADD, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("flush_hold", dut_flags(), 4'b1010);
    bus_if.wr_en = 1'b1; bus_if.wr_data = 4'b1111;
    alu(CMD_ADD, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("wr_beats_alu", dut_flags(), 4'b1111);

    bus_if.save_req = 1'b1; step();
    wr(4'b0000);
    bus_if.save_req = 1'b1; bus_if.restore_req = 1'b1; step();
    chk("swap_flags", dut_flags(), 4'b1111);
    chk("swap_sv", bus_if.shadow_valid, 1'b1);
    bus_if.restore_req = 1'b1; step();
    chk("swap_restore", dut_flags(), 4'b0000);
    bus_if.restore_req = 1'b1; bus_if.wr_en = 1'b1; bus_if.wr_data = 4'b0110; step();
    chk("restore_idle", {dut_flags(), bus_if.shadow_valid}, 5'b0110_0);
    bus_if.save_req = 1'b1; bus_if.wr_en = 1'b1; bus_if.wr_data = 4'b1100; step();
    bus_if.restore_req = 1'b1; step();
    chk("save_preupd", dut_flags(), 4'b0110);
    bus_if.stall = 1'b1; bus_if.save_req = 1'b1; step();
    chk("stall_save", bus_if.shadow_valid, 1'b0);

    for (int i = 0; i < 300; i++) begin
      bus_if.alu_res     = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
      bus_if.alu_cout    = 1'($urandom());
      bus_if.op_a_msb    = 1'($urandom());
      bus_if.op_b_msb    = 1'($urandom());
      bus_if.exe_cmd     = 4'($urandom());
      bus_if.s_bit       = 1'($urandom());
      bus_if.exe_valid   = ($urandom_range(0, 3) != 0);
      bus_if.stall       = ($urandom_range(0, 5) == 0);
      bus_if.flush       = ($urandom_range(0, 5) == 0);
      bus_if.wr_en       = ($urandom_range(0, 4) == 0);
      bus_if.wr_data     = 4'($urandom());
      bus_if.save_req    = ($urandom_range(0, 5) == 0);
      bus_if.restore_req = ($urandom_range(0, 5) == 0);
      step();
    end

    wr(4'b1111);
    bus_if.save_req = 1'b1; step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_flags", dut_flags(), 4'b0000);
    chk("async_rst_sv", bus_if.shadow_valid, 1'b0);
    m_flags = '0; m_shadow = '0; m_saved = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
    bus_if.restore_req = 1'b1; step();
    chk("post_rst", {dut_flags(), bus_if.shadow_valid}, 5'b0000_0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
